// File: rtl/ibuf_lvcmos12_filt_if.sv
// Pad-input filter bus: enable, raw pad level and counter clear in; filtered level,
// edge/glitch strobes and glitch count out.
interface ibuf_lvcmos12_filt_if #(
    parameter int unsigned GCNT_W = 8
);
    logic              ce;
    logic              i;
    logic              clr_cnt;
    logic              o;
    logic              rise;
    logic              fall;
    logic              glitch;
    logic [GCNT_W-1:0] glitch_cnt;

    modport master (
        output ce, i, clr_cnt,
        input  o, rise, fall, glitch, glitch_cnt
    );

    modport slave (
        input  ce, i, clr_cnt,
        output o, rise, fall, glitch, glitch_cnt
    );
endinterface

// File: rtl/ibuf_lvcmos12_filt.sv
// Synchronizes an asynchronous LVCMOS12 pad input, filters short pulses, and reports
// accepted edges and rejected glitches as one-cycle strobes plus a saturating count.
module ibuf_lvcmos12_filt #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        INIT          = 1'b0,
    parameter int unsigned GCNT_W        = 8
) (
    input logic                 C,
    input logic                 R,
    ibuf_lvcmos12_filt_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   o_q, o_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GCNT_W-1:0]      gcnt_q, gcnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   glitch_q, glitch_d;
    logic                   s;
    logic                   s_known;

    assign s = sync_q[SYNC_STAGES-1];
    // An unresolved sample is treated as "no change" so X never reaches O.
    assign s_known = !$isunknown(s);

    always_comb begin
        sync_d   = sync_q;
        o_d      = o_q;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        if (bus.ce) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], bus.i};
            if (s_known) begin
                if (s != o_q) begin
                    if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                        o_d    = s;
                        cnt_d  = '0;
                        rise_d = s;
                        fall_d = ~s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q != '0) begin
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                    if (gcnt_q != {GCNT_W{1'b1}}) begin
                        gcnt_d = gcnt_q + GCNT_W'(1);
                    end
                end
            end
            // Clear wins over a same-cycle increment; the GLITCH strobe is unaffected.
            if (bus.clr_cnt) begin
                gcnt_d = '0;
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            sync_q   <= {SYNC_STAGES{INIT}};
            o_q      <= INIT;
            cnt_q    <= '0;
            gcnt_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            o_q      <= o_d;
            cnt_q    <= cnt_d;
            gcnt_q   <= gcnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.o          = o_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.glitch     = glitch_q;
    assign bus.glitch_cnt = gcnt_q;

`ifndef SYNTHESIS
    strobes_exclusive_a: assert property (@(posedge C) disable iff (R)
        $onehot0({rise_q, fall_q, glitch_q}));
    strobes_single_a: assert property (@(posedge C) disable iff (R)
        !((rise_q && $past(rise_q)) || (fall_q && $past(fall_q))
          || (glitch_q && $past(glitch_q))));
`endif
endmodule
